// File: rtl/booth_radix4_mult_if.sv
// Load/done multiply handshake between a host and the Booth multiplier.
// The host drives the operands and load; the multiplier returns product and done.
interface booth_radix4_mult_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   r;
    logic               load;
    logic [2*WIDTH-1:0] product;
    logic               done;

    modport master (output m, output r, output load, input product, input done);
    modport slave  (input m, input r, input load, output product, output done);
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential signed radix-4 Booth multiplier that retires two multiplier bits per clock.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand finishes in one cycle instead of WIDTH/2.
module booth_radix4_mult #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    booth_radix4_mult_if.slave  bus
);

    localparam int CW = $clog2(WIDTH / 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ZERO
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH+1:0]     mcand;
    logic [WIDTH+1:0]     a;
    logic [WIDTH-1:0]     q;
    logic                 qm1;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic                 done_c;

    logic [WIDTH+1:0]     term;
    logic [WIDTH+1:0]     sum;
    logic signed [2*WIDTH+2:0] shifted;
    logic [WIDTH+1:0]     a_next;
    logic [WIDTH-1:0]     q_next;
    logic                 qm1_next;

`ifdef BOOTH_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (bus.m == '0) || (bus.r == '0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.load) begin
`ifdef BOOTH_ZERO_SKIP_EN
                    if (zero_op) begin
                        state_next = ZERO;
                    end else begin
                        state_next = CALC;
                    end
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done_c = (state == IDLE);
    end

    // One radix-4 step: add the recoded multiple of M, then shift {A,Q,q_m1} right by two.
    always_comb begin
        case ({q[1:0], qm1})
            3'b001, 3'b010: term = mcand;
            3'b011:         term = mcand << 1;
            3'b100:         term = -(mcand << 1);
            3'b101, 3'b110: term = -mcand;
            default:        term = '0;
        endcase
        sum     = a + term;
        shifted = $signed({sum, q, qm1}) >>> 2;
    end

    assign a_next   = shifted[2*WIDTH+2:WIDTH+1];
    assign q_next   = shifted[WIDTH:1];
    assign qm1_next = shifted[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand     <= '0;
            a         <= '0;
            q         <= '0;
            qm1       <= 1'b0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        mcand <= {{2{bus.m[WIDTH-1]}}, bus.m};
                        q     <= bus.r;
                        qm1   <= 1'b0;
                        a     <= '0;
                        cnt   <= CNT_INIT;
                    end
                end
                CALC: begin
                    a   <= a_next;
                    q   <= q_next;
                    qm1 <= qm1_next;
                    if (cnt == '0) begin
                        product_q <= {a_next[WIDTH-1:0], q_next};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef BOOTH_ZERO_SKIP_EN
                ZERO: begin
                    product_q <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.done    = done_c;
    assign bus.product = product_q;

endmodule
